// File: rtl/camera_tx_pkg.sv
// Shared types and constants for the parallel camera transmitter.
package camera_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBP    = 3'd2,
    LINE   = 3'd3,
    HBLANK = 3'd4
  } cam_tx_state_e;

  localparam logic CAM_TX_MSB_FIRST = 1'b0;
  localparam logic CAM_TX_LSB_FIRST = 1'b1;

endpackage

// File: rtl/camera_tx_clkgen.sv
// Pixel-clock divider: produces cam_clk and a tick strobe in the cycle where
// the pixel clock falls, so downstream logic changes on the falling edge.
module camera_tx_clkgen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 run_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 cam_clk_o,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic                 clk_q;
  logic                 active_q;
  logic                 wrap;

  assign wrap      = run_i && (cnt_q == div_q);
  assign tick_o    = wrap && clk_q;
  assign cam_clk_o = clk_q;

  // The divider value is tracked while stopped and frozen once running.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div_q    <= '0;
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      active_q <= run_i;
      if (!active_q) div_q <= div_i;
      if (!run_i) begin
        cnt_q <= '0;
        clk_q <= 1'b0;
      end else if (wrap) begin
        cnt_q <= '0;
        clk_q <= ~clk_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/camera_tx_gen.sv
// Parallel camera transmitter: frames uDMA pixel words into VSYNC/HSYNC
// timed byte stream, two bytes per 16-bit pixel.
module camera_tx_gen
  import camera_tx_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int VSYNC_W   = 2,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_clkdiv_i,
  input  logic [CNT_WIDTH-1:0] cfg_rowlen_i,
  input  logic [CNT_WIDTH-1:0] cfg_rows_i,
  input  logic [CNT_WIDTH-1:0] cfg_hblank_i,
  input  logic [CNT_WIDTH-1:0] cfg_vblank_i,
  input  logic                 cfg_byteswap_i,
  input  logic [15:0]          data_tx_data_i,
  input  logic                 data_tx_valid_i,
  output logic                 data_tx_ready_o,
  output logic                 cam_clk_o,
  output logic [7:0]           cam_data_o,
  output logic                 cam_hsync_o,
  output logic                 cam_vsync_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 underrun_o
);

  localparam logic [CNT_WIDTH-1:0] VS_LAST = CNT_WIDTH'(VSYNC_W - 1);

  cam_tx_state_e        state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] row_q, row_d;
  logic [CNT_WIDTH:0]   col_q, col_d;
  logic [CNT_WIDTH-1:0] rowlen_q, rows_q, hblank_q, vblank_q;
  logic                 byteswap_q;
  logic [15:0]          buf_q;
  logic                 full_q;
  logic [7:0]           sav_q, sav_d;
  logic [7:0]           data_q, data_d;
  logic                 hs_q, hs_d, vs_q, vs_d;
  logic                 under_q, under_d, done_q, done_d;
  logic                 shadow_ld, pop, start_px, tick, run, load;
  logic [7:0]           first_byte, second_byte;

  assign busy_o          = (state_q != IDLE);
  assign run             = cfg_en_i | busy_o;
  assign data_tx_ready_o = ~full_q;
  assign load            = data_tx_valid_i & ~full_q;
  assign cam_data_o      = data_q;
  assign cam_hsync_o     = hs_q;
  assign cam_vsync_o     = vs_q;
  assign frame_done_o    = done_q;
  assign underrun_o      = under_q;

  assign first_byte  = (byteswap_q == CAM_TX_LSB_FIRST) ? buf_q[7:0]  : buf_q[15:8];
  assign second_byte = (byteswap_q == CAM_TX_LSB_FIRST) ? buf_q[15:8] : buf_q[7:0];

  camera_tx_clkgen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clkgen (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .run_i     (run),
    .div_i     (cfg_clkdiv_i),
    .cam_clk_o (cam_clk_o),
    .tick_o    (tick)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    data_d    = data_q;
    sav_d     = sav_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    under_d   = 1'b0;
    done_d    = 1'b0;
    shadow_ld = 1'b0;
    start_px  = 1'b0;
    pop       = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          state_d   = VSYNC;
          vs_d      = 1'b1;
          cnt_d     = '0;
          shadow_ld = 1'b1;
        end
        VSYNC: begin
          if (cnt_q == VS_LAST) begin
            state_d = VBP;
            vs_d    = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        VBP: begin
          if (cnt_q == vblank_q) begin
            state_d  = LINE;
            hs_d     = 1'b1;
            col_d    = '0;
            row_d    = '0;
            start_px = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LINE: begin
          // col_q counts bytes; the last byte of the line is 2*rowlen+1.
          if (col_q == {rowlen_q, 1'b1}) begin
            state_d = HBLANK;
            hs_d    = 1'b0;
            data_d  = 8'h00;
            cnt_d   = '0;
          end else begin
            col_d = col_q + 1'b1;
            if (col_q[0]) start_px = 1'b1;
            else          data_d   = sav_q;
          end
        end
        HBLANK: begin
          if (cnt_q != hblank_q) begin
            cnt_d = cnt_q + 1'b1;
          end else if (row_q == rows_q) begin
            done_d = 1'b1;
            row_d  = '0;
            cnt_d  = '0;
            if (cfg_en_i) begin
              state_d   = VSYNC;
              vs_d      = 1'b1;
              shadow_ld = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d  = LINE;
            row_d    = row_q + 1'b1;
            hs_d     = 1'b1;
            col_d    = '0;
            start_px = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // An empty buffer still consumes the pixel slot so line timing holds.
    if (start_px) begin
      if (full_q) begin
        data_d = first_byte;
        sav_d  = second_byte;
        pop    = 1'b1;
      end else begin
        data_d  = 8'h00;
        sav_d   = 8'h00;
        under_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      data_q     <= '0;
      sav_q      <= '0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      under_q    <= 1'b0;
      done_q     <= 1'b0;
      rowlen_q   <= '0;
      rows_q     <= '0;
      hblank_q   <= '0;
      vblank_q   <= '0;
      byteswap_q <= CAM_TX_MSB_FIRST;
      buf_q      <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      sav_q   <= sav_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      under_q <= under_d;
      done_q  <= done_d;
      if (shadow_ld) begin
        rowlen_q   <= cfg_rowlen_i;
        rows_q     <= cfg_rows_i;
        hblank_q   <= cfg_hblank_i;
        vblank_q   <= cfg_vblank_i;
        byteswap_q <= cfg_byteswap_i;
      end
      if (load) begin
        buf_q  <= data_tx_data_i;
        full_q <= 1'b1;
      end else if (pop) begin
        full_q <= 1'b0;
      end
    end
  end

endmodule
